iob_fifo2stream: RTL and testbench

//  Read-side companion of the team's synchronous FIFO. Drains the FIFO read port (r_en/r_data/r_empty)
//  and presents the data as a valid/ready stream. Hides the FIFO's 1-cycle read latency with a 2-entry

---
 rtl/iob_fifo2stream_pkg.sv | 25 ++
 rtl/iob_fifo2stream_buf.sv | 50 +++++
 rtl/iob_fifo2stream.sv | 96 +++++++++
 tb/tb_iob_fifo2stream.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_fifo2stream_pkg.sv
// Shared constants and helpers for iob_fifo2stream.
// With IOB_FIFO2STREAM_TLAST_EN defined, each buffer entry carries one extra m_last tag bit.
package iob_fifo2stream_pkg;

   localparam int unsigned BUF_DEPTH  = 2;
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_CNT_W  = 16;
   localparam int unsigned DEF_LEN_W  = 16;

`ifdef IOB_FIFO2STREAM_TLAST_EN
   localparam int unsigned TAG_W = 1;
`else
   localparam int unsigned TAG_W = 0;
`endif

   typedef logic [1:0] occ_t;

   // A read may issue only if its data is guaranteed a free buffer slot when it lands
   function automatic logic can_issue(input occ_t occ, input logic infl, input logic pop);
      logic [2:0] w_used;
      w_used = {1'b0, occ} + {2'b00, infl};
      return w_used < (3'(BUF_DEPTH) + {2'b00, pop});
   endfunction

endpackage

// File: rtl/iob_fifo2stream_buf.sv
// Two-entry in-order output buffer; the head entry drives the stream outputs directly from a register.
module iob_fifo2stream_buf
   import iob_fifo2stream_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_valid,
   output occ_t         o_occ
);

   logic [W-1:0] r_head;
   logic [W-1:0] r_tail;
   occ_t         r_occ;
   occ_t         w_slot;

   // Slot the incoming word lands in, after any same-cycle pop has shifted the tail forward
   assign w_slot = r_occ - 2'(i_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: both entries are cleared so m_data (and the last tag) read 0 out of reset
         r_head <= '0;
         r_tail <= '0;
         r_occ  <= '0;
      end else begin
         if (i_pop) begin
            r_head <= r_tail;
         end
         if (i_push) begin
            if (w_slot == 2'd0) begin
               r_head <= i_data;
            end else begin
               r_tail <= i_data;
            end
         end
         r_occ <= r_occ + 2'(i_push) - 2'(i_pop);
      end
   end

   assign o_data  = r_head;
   assign o_valid = (r_occ != 2'd0);
   assign o_occ   = r_occ;

endmodule

// File: rtl/iob_fifo2stream.sv
// Drains an iob FIFO read port into a valid/ready stream at one beat per cycle.
// Optional packet framing (m_last, pkt_len) is enabled by defining IOB_FIFO2STREAM_TLAST_EN.
module iob_fifo2stream
   import iob_fifo2stream_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned CNT_W  = DEF_CNT_W,
   parameter int unsigned LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic              fifo_r_en,
   input  logic [DATA_W-1:0] fifo_r_data,
   input  logic              fifo_r_empty,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready,
   output logic [CNT_W-1:0]  beat_cnt
`ifdef IOB_FIFO2STREAM_TLAST_EN
   ,
   output logic              m_last,
   input  logic [LEN_W-1:0]  pkt_len
`endif
);

   localparam int unsigned BUF_W = DATA_W + TAG_W;

   logic             r_infl;
   logic [CNT_W-1:0] r_beat_cnt;
   logic             w_pop;
   occ_t             w_occ;
   logic [BUF_W-1:0] w_push_data;
   logic [BUF_W-1:0] w_head;

   assign w_pop = m_valid & m_ready;

   // m_ready reaches fifo_r_en combinationally so a pop frees a slot in the same cycle
   assign fifo_r_en = en & ~fifo_r_empty & ~rst & can_issue(w_occ, r_infl, w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_infl     <= 1'b0;
         r_beat_cnt <= '0;
      end else begin
         r_infl     <= fifo_r_en;
         r_beat_cnt <= r_beat_cnt + CNT_W'(w_pop);
      end
   end

   assign beat_cnt = r_beat_cnt;

`ifdef IOB_FIFO2STREAM_TLAST_EN
   logic [LEN_W-1:0] r_pkt_pos;
   logic [LEN_W-1:0] r_pkt_len;
   logic [LEN_W-1:0] w_len;
   logic             w_last;

   // Packet length is taken live on the first beat, then held for the rest of the packet
   assign w_len  = (r_pkt_pos == '0) ? pkt_len : r_pkt_len;
   assign w_last = (w_len == '0) || (r_pkt_pos == w_len - LEN_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pkt_pos <= '0;
         r_pkt_len <= '0;
      end else if (r_infl) begin
         if (r_pkt_pos == '0) begin
            r_pkt_len <= pkt_len;
         end
         r_pkt_pos <= w_last ? '0 : r_pkt_pos + LEN_W'(1);
      end
   end

   assign w_push_data = {w_last, fifo_r_data};
   assign m_last      = w_head[DATA_W];
`else
   assign w_push_data = fifo_r_data;
`endif

   iob_fifo2stream_buf #(
      .W(BUF_W)
   ) u_buf (
      .clk    (clk),
      .rst    (rst),
      .i_push (r_infl),
      .i_data (w_push_data),
      .i_pop  (w_pop),
      .o_data (w_head),
      .o_valid(m_valid),
      .o_occ  (w_occ)
   );

   assign m_data = w_head[DATA_W-1:0];

endmodule

// File: tb/tb_iob_fifo2stream.sv
// Self-checking bench for iob_fifo2stream against a behavioural FIFO (registered empty, 1-cycle read latency)
// and an in-order scoreboard of every word written since the last reset.
module tb_iob_fifo2stream;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 16;
   localparam int LEN_W  = 16;

   logic              clk          = 1'b0;
   logic              rst          = 1'b1;
   logic              en           = 1'b0;
   logic              m_ready      = 1'b0;
   logic              wr_en        = 1'b0;
   logic [DATA_W-1:0] wr_data      = '0;
   logic              fifo_r_empty = 1'b1;
   logic [DATA_W-1:0] fifo_r_data  = '0;
   logic              fifo_r_en;
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic [CNT_W-1:0]  beat_cnt;
`ifdef IOB_FIFO2STREAM_TLAST_EN
   logic              m_last;
   logic [LEN_W-1:0]  pkt_len = '0;
`endif

   always #5 clk = ~clk;

   iob_fifo2stream #(
      .DATA_W(DATA_W),
      .CNT_W (CNT_W),
      .LEN_W (LEN_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .fifo_r_en   (fifo_r_en),
      .fifo_r_data (fifo_r_data),
      .fifo_r_empty(fifo_r_empty),
      .m_valid     (m_valid),
      .m_data      (m_data),
      .m_ready     (m_ready),
      .beat_cnt    (beat_cnt)
`ifdef IOB_FIFO2STREAM_TLAST_EN
      ,
      .m_last      (m_last),
      .pkt_len     (pkt_len)
`endif
   );

   // Behavioural source FIFO plus a log of every word written since reset
   logic [DATA_W-1:0] fq[$];
   logic [DATA_W-1:0] wr_log [0:4095];
   int                n_wr     = 0;
   int                fifo_cnt = 0;

   always @(posedge clk) begin
      if (rst) begin
         fq.delete();
         fifo_r_empty <= 1'b1;
         fifo_r_data  <= '0;
         n_wr         <= 0;
         fifo_cnt     <= 0;
      end else begin
         if (fifo_r_en && fq.size() > 0) fifo_r_data <= fq.pop_front();
         if (wr_en) begin
            fq.push_back(wr_data);
            wr_log[n_wr] <= wr_data;
            n_wr         <= n_wr + 1;
         end
         fifo_r_empty <= (fq.size() == 0);
         fifo_cnt     <= fq.size();
      end
   end

   int                n_cmp  = 0;
   int                n_fail = 0;
   int                cyc    = 0;
   int                rd_idx = 0;
   int                rd_issued = 0;
   int                m_pops = 0;
   int                n_last = 0;
   int                pop_first = -1;
   int                pop_last  = -1;
   logic              prev_hold = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle protocol and scoreboard checks, sampled mid-cycle
   task automatic monitor();
      if (rst) begin
         rd_idx    = 0;
         rd_issued = 0;
         m_pops    = 0;
         n_last    = 0;
         prev_hold = 1'b0;
         return;
      end
      check("beat_cnt", 64'(beat_cnt), 64'(m_pops[CNT_W-1:0]));
      if (prev_hold) begin
         check("hold_valid", m_valid, 1'b1);
         check("hold_data", m_data, prev_data);
      end
      if (fifo_r_en) begin
         check("rd_while_empty", fifo_r_empty, 1'b0);
         rd_issued++;
      end
      if (m_valid && m_ready) begin
         check("beat_in_range", rd_idx < n_wr, 1'b1);
         if (rd_idx < n_wr) check("beat_data", m_data, wr_log[rd_idx]);
`ifdef IOB_FIFO2STREAM_TLAST_EN
         begin
            int len;
            len = (pkt_len == '0) ? 1 : int'(pkt_len);
            check("m_last", m_last, (m_pops % len) == len - 1);
            if (m_last) n_last++;
         end
`endif
         if (pop_first < 0) pop_first = cyc;
         pop_last = cyc;
         rd_idx++;
         m_pops++;
      end
      check("outstanding_le_2", (rd_issued - m_pops) <= 2, 1'b1);
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #2;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; m_ready = 1'b0; wr_en = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic load_words(input int n, input int base);
      for (int k = 0; k < n; k++) begin
         wr_en   = 1'b1;
         wr_data = DATA_W'(base + k);
         tick();
      end
      wr_en = 1'b0;
      tick();
   endtask

   task automatic drain(input string name, input int budget);
      int k;
      k = 0;
      en = 1'b1; m_ready = 1'b1; wr_en = 1'b0;
      while ((rd_idx != n_wr || m_valid) && k < budget) begin
         tick();
         k++;
      end
      check(name, (rd_idx == n_wr) && !m_valid, 1'b1);
   endtask

   typedef struct {
      int         n_words;
      logic [3:0] ready_pat;
      int         n_cycles;
      int         exp_beats;
      int         exp_span;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int rise;
      int base_pops;
      int rd_mark;

      vecs[0] = '{8,  4'b1111, 30, 8,  7};
      vecs[1] = '{16, 4'b1001, 80, 16, -1};
      vecs[2] = '{1,  4'b1111, 20, 1,  0};
      vecs[3] = '{5,  4'b0101, 40, 5,  -1};
      vecs[4] = '{16, 4'b1111, 40, 16, 15};

      // Reset state
      do_reset();
      check("rst_m_valid", m_valid, 1'b0);
      check("rst_m_data", m_data, '0);
      check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
      check("rst_fifo_r_en", fifo_r_en, 1'b0);

      // Table-driven bursts: preload, then stream with a repeating ready pattern
      for (int v = 0; v < 5; v++) begin
         do_reset();
         load_words(vecs[v].n_words, v << 8);
         pop_first = -1;
         en = 1'b1;
         for (int c = 0; c < vecs[v].n_cycles; c++) begin
            m_ready = vecs[v].ready_pat[c % 4];
            tick();
         end
         check($sformatf("vec%0d_beats", v), 64'(m_pops), 64'(vecs[v].exp_beats));
         check($sformatf("vec%0d_beat_cnt", v), 64'(beat_cnt), 64'(vecs[v].exp_beats));
         if (vecs[v].exp_span >= 0)
            check($sformatf("vec%0d_span", v), 64'(pop_last - pop_first), 64'(vecs[v].exp_span));
      end

      // Latency from a single write into an idle, empty FIFO
      do_reset();
      en = 1'b1; m_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_no_valid", m_valid, 1'b0);
      end
      wr_en = 1'b1; wr_data = 32'hA5A5_0001;
      tick();
      wr_en = 1'b0;
      rise = -1;
      base_pops = m_pops;
      for (int i = 1; i <= 8; i++) begin
         if (m_valid && rise < 0) rise = i;
         tick();
      end
      check("lat_valid_seen", rise > 0, 1'b1);
      check("lat_min_2", rise >= 2, 1'b1);
      check("lat_one_beat", 64'(m_pops - base_pops), 64'd1);

      // en dropped with a read in flight while the consumer stalls
      do_reset();
      load_words(10, 32'h100);
      en = 1'b1; m_ready = 1'b0;
      tick();
      tick();
      en = 1'b0;
      rd_mark = rd_issued;
      for (int i = 0; i < 6; i++) tick();
      check("en_drop_reads_stop", 64'(rd_issued), 64'(rd_mark));
      check("en_drop_reads", 64'(rd_issued), 64'd2);
      check("en_drop_held_valid", m_valid, 1'b1);
      m_ready = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      check("en_drop_beats", 64'(m_pops), 64'd2);
      check("en_drop_halt", m_valid, 1'b0);
      drain("en_drop_drain", 60);

      // Reset in the middle of a transfer
      do_reset();
      load_words(10, 32'h200);
      en = 1'b1; m_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      m_ready = 1'b0;
      tick();
      check("pre_rst_busy", m_valid, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_m_valid", m_valid, 1'b0);
      check("mid_rst_beat_cnt", 64'(beat_cnt), 64'd0);
      check("mid_rst_fifo_r_en", fifo_r_en, 1'b0);
      check("mid_rst_m_data", m_data, '0);
      for (int i = 0; i < 4; i++) tick();
      check("post_rst_quiet", m_valid, 1'b0);

      // Randomized traffic against the scoreboard
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         en      = ($urandom_range(7) != 0);
         m_ready = ($urandom_range(2) != 0);
         wr_en   = (fifo_cnt < 14) && ($urandom_range(1) == 1);
         wr_data = $urandom;
         tick();
      end
      drain("rand_drain", 200);

`ifdef IOB_FIFO2STREAM_TLAST_EN
      do_reset();
      pkt_len = LEN_W'(3);
      load_words(7, 32'h300);
      drain("tlast3_drain", 60);
      check("tlast3_count", 64'(n_last), 64'd2);
      do_reset();
      pkt_len = '0;
      load_words(7, 32'h400);
      drain("tlast0_drain", 60);
      check("tlast0_count", 64'(n_last), 64'd7);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
